// File: rtl/gyro_pkg.sv
// Shared types, defaults and arithmetic helpers for the gyro tilt integrator.
package gyro_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StRd,
    StUpd,
    StPub
  } state_e;

  // 1 ms tick at 50 MHz; /1024 approximates /1000 for dps -> degrees per tick
  localparam int unsigned SAMPLE_DIV_1MS     = 50000;
  localparam int unsigned FRAC_SHIFT_DPS_1MS = 10;

  // Clamp a wide signed value to the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned         w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Signed add that saturates to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned         w);
    return sat_clamp(a + b, w);
  endfunction

  // Values strictly inside (lo, hi) are treated as sensor noise and squashed to zero.
  function automatic logic signed [63:0] deadband(input logic signed [63:0] v,
                                                  input logic signed [63:0] lo,
                                                  input logic signed [63:0] hi);
    return (v > lo && v < hi) ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/gyro_window_buf.sv
// Per-channel circular sample store: CH x DEPTH words, registered read, single write.
module gyro_window_buf #(
  parameter int unsigned CH    = 3,
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [$clog2(DEPTH)-1:0]            wptr_i,
  input  logic                                rd_en_i,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] rd_ch_i,
  output logic [W-1:0]                        rd_data_o,
  input  logic                                wr_en_i,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch_i,
  input  logic [W-1:0]                        wr_data_i
);

  localparam int unsigned Entries = CH * DEPTH;

  logic [W-1:0] mem_q [Entries];
  logic [W-1:0] mem_d [Entries];
  logic [W-1:0] rd_data_q, rd_data_d;

  // DEPTH is a power of two, so {ch, wptr} equals ch*DEPTH + wptr
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem_q[{rd_ch_i, wptr_i}];
    if (wr_en_i) mem_d[{wr_ch_i, wptr_i}] = wr_data_i;
  end

  // Storage and read register, cleared on reset so windows start zero-filled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gyro_tilt_integrator.sv
// Serial multi-channel gyro rate -> tilt integrator with moving average and deadband.
module gyro_tilt_integrator
  import gyro_pkg::*;
#(
  parameter int unsigned CH         = 3,
  parameter int unsigned W          = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_1MS,
  parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DPS_1MS,
  parameter int          DEAD_LO    = -42,
  parameter int          DEAD_HI    = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CH*W-1:0] rate_in,
  input  logic            rate_valid,
  input  logic            zero,
  output logic [CH*W-1:0] tilt_out,
  output logic            tilt_valid,
  output logic            busy,
  output logic [CH-1:0]   sat_flag
);

  localparam int unsigned LogD = $clog2(DEPTH);
  localparam int unsigned SumW = W + LogD;
  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  state_e                   state_q, state_d;
  logic [DivW-1:0]          div_q, div_d;
  logic [ChW-1:0]           ch_q, ch_d;
  logic [LogD-1:0]          wptr_q, wptr_d;
  logic [CH*W-1:0]          shadow_q, shadow_d;
  logic [CH*W-1:0]          sample_q, sample_d;
  logic [CH*W-1:0]          tilt_q, tilt_d;
  logic [CH-1:0]            sat_q, sat_d;
  logic signed [SumW-1:0]   sum_q [CH];
  logic signed [SumW-1:0]   sum_d [CH];
  logic signed [ACC_W-1:0]  acc_q [CH];
  logic signed [ACC_W-1:0]  acc_d [CH];

  logic                     tick;
  logic                     rd_en, wr_en, pub;
  logic [W-1:0]             rd_data;
  logic signed [W-1:0]      new_s, old_s;
  logic signed [SumW-1:0]   cur_sum, avg;
  logic signed [63:0]       dead, raw, acc_sat;
  logic                     sat_hit;
  logic [CH*W-1:0]          pub_tilt;

  // Free-running sample divider and input shadow, both independent of the FSM
  always_comb begin
    tick     = (div_q == DivW'(SAMPLE_DIV - 1));
    div_d    = tick ? '0 : div_q + DivW'(1);
    shadow_d = rate_valid ? rate_in : shadow_q;
  end

  // Shared datapath for the channel currently selected by ch_q
  always_comb begin
    new_s   = sample_q[ch_q*W +: W];
    old_s   = rd_data;
    cur_sum = sum_q[ch_q] + SumW'(new_s) - SumW'(old_s);
    avg     = cur_sum >>> LogD;
    dead    = deadband(64'(avg), 64'(DEAD_LO), 64'(DEAD_HI));
    raw     = 64'(acc_q[ch_q]) + dead;
    acc_sat = sat_add(64'(acc_q[ch_q]), dead, ACC_W);
    sat_hit = (acc_sat != raw);
  end

  // FSM next state, per-channel updates, zero override and publish values
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    wptr_d   = wptr_q;
    sample_d = sample_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    tilt_d   = tilt_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    pub      = 1'b0;
    pub_tilt = '0;

    case (state_q)
      StIdle: if (tick) state_d = StSnap;
      StSnap: begin
        sample_d = shadow_q;
        ch_d     = '0;
        state_d  = StRd;
      end
      StRd: begin
        rd_en   = 1'b1;
        state_d = StUpd;
      end
      StUpd: begin
        wr_en              = 1'b1;
        sum_d[ch_q]        = cur_sum;
        acc_d[ch_q]        = ACC_W'(acc_sat);
        if (sat_hit) sat_d[ch_q] = 1'b1;
        if (ch_q == ChW'(CH - 1)) begin
          state_d = StPub;
        end else begin
          ch_d    = ch_q + ChW'(1);
          state_d = StRd;
        end
      end
      StPub: begin
        wptr_d  = wptr_q + LogD'(1);
        pub     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // zero wins over the accumulate of the same cycle; windows and sums are untouched
    if (zero) begin
      for (int k = 0; k < CH; k++) acc_d[k] = '0;
      sat_d = '0;
    end

    for (int k = 0; k < CH; k++) begin
      pub_tilt[k*W +: W] = W'(sat_clamp(64'(acc_d[k]) >>> FRAC_SHIFT, W));
    end
    if (pub) tilt_d = pub_tilt;
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      div_q    <= '0;
      ch_q     <= '0;
      wptr_q   <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      tilt_q   <= '0;
      sat_q    <= '0;
      sum_q    <= '{default: '0};
      acc_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ch_q     <= ch_d;
      wptr_q   <= wptr_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      tilt_q   <= tilt_d;
      sat_q    <= sat_d;
      sum_q    <= sum_d;
      acc_q    <= acc_d;
    end
  end

  gyro_window_buf #(
    .CH   (CH),
    .W    (W),
    .DEPTH(DEPTH)
  ) u_window_buf (
    .clk_i    (CLK),
    .rst_i    (RST),
    .wptr_i   (wptr_q),
    .rd_en_i  (rd_en),
    .rd_ch_i  (ch_q),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en),
    .wr_ch_i  (ch_q),
    .wr_data_i(new_s)
  );

  // Publish cycle drives the fresh values so a same-cycle zero shows as 0
  assign tilt_out   = pub ? pub_tilt : tilt_q;
  assign tilt_valid = pub;
  assign busy       = (state_q != StIdle);
  assign sat_flag   = sat_q;

endmodule
